// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity types,
// legal prescale values and small helper functions.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  // Expected parity bit given the XOR of all data bits and the parity type.
  // Even parity sends ^data; odd parity sends ~^data.
  function automatic logic expected_parity(input logic data_xor, input logic par_typ);
    return data_xor ^ par_typ;
  endfunction

  // Two-out-of-three vote over the samples taken around the bit centre.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the receiver: counts clocks within a bit, captures three
// samples around the bit centre and presents their majority at bit end.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]            samples_q, samples_d;
  logic [PRESCALE_W-1:0] half;

  // Edge counter wraps at P-1; samples are captured at P/2-2, P/2-1 and P/2.
  always_comb begin
    half       = prescale >> 1;
    bit_end    = run && (edge_cnt_q == prescale - PRESCALE_W'(1));
    edge_cnt_d = edge_cnt_q;
    samples_d  = samples_q;
    if (!run || bit_end) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
    if (run) begin
      if (edge_cnt_q == half - PRESCALE_W'(2)) samples_d[0] = rx_in;
      if (edge_cnt_q == half - PRESCALE_W'(1)) samples_d[1] = rx_in;
      if (edge_cnt_q == half)                  samples_d[2] = rx_in;
    end
    sampled_bit = majority3(samples_q);
  end

  // Counter and sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      samples_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samples_q  <= samples_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: detects the start bit, deserialises LSB-first data,
// checks optional parity and the stop bit, and emits one end-of-frame pulse.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic sampled_bit;
  logic bit_end;
  logic run;

  assign run = (state_q != ST_IDLE);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_in       (RX_IN),
    .run         (run),
    .prescale    (prescale_q),
    .sampled_bit (sampled_bit),
    .bit_end     (bit_end)
  );

  // Next-state, framing checks and end-of-frame pulse generation.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d    = ST_START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_bad_d  = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          if (!sampled_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          par_bad_d = (sampled_bit != expected_parity(^shift_q, par_typ_q));
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          if (sampled_bit && !par_bad_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end else begin
            par_err_d = par_bad_q;
            stp_err_d = !sampled_bit;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push their expected
// end-of-frame result into a queue; a monitor pops and compares on each pulse.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_core #(
    .DATA_WIDTH (DW),
    .PRESCALE_W (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Posedge count; the value seen at a negedge is the index of the last edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Single comparison point shared by the monitor and the stimulus process.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_expect(input logic dv, input logic pe, input logic se,
                             input logic [7:0] data, input int exp_cyc);
    exp_q.push_back('{dv, pe, se, data, exp_cyc});
  endtask

  // Holds one serial bit for p clocks; optionally inverts the line for the
  // single clock that carries the centre sample.
  task automatic drive_bit(input logic v, input int p, input bit glitch);
    RX_IN = v;
    if (glitch) begin
      repeat (p / 2) @(negedge CLK);
      RX_IN = ~v;
      @(negedge CLK);
      RX_IN = v;
      repeat (p / 2 - 1) @(negedge CLK);
    end else begin
      repeat (p) @(negedge CLK);
    end
  endtask

  // Sends one complete frame starting at a negedge; line returns to idle high.
  task automatic apply_stimulus(input logic [7:0] data, input int p, input logic par_en,
                                input logic par_bit, input logic stop_bit, input bit glitch);
    drive_bit(1'b0, p, glitch);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p, glitch);
    if (par_en) drive_bit(par_bit, p, glitch);
    drive_bit(stop_bit, p, glitch);
    RX_IN = 1'b1;
  endtask

  // Monitor: every pulse cycle must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b at cycle %0d, required no pulse",
                 data_valid, par_err, stp_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("pulse_flags", {29'd0, data_valid, par_err, stp_err},
                     {29'd0, mon_e.dv, mon_e.pe, mon_e.se});
        check_output("p_data_at_pulse", 32'(P_DATA), 32'(mon_e.data));
        if (mon_e.exp_cyc >= 0) check_output("pulse_cycle", cyc, mon_e.exp_cyc);
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values.
    #1;
    check_output("reset_p_data", 32'(P_DATA), 32'h0);
    check_output("reset_pulses", {29'd0, data_valid, par_err, stp_err}, 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    // P=8 even parity, 0xA5 clean; pulse observed 88 edges after the
    // detection edge, i.e. clock 89 counting the detection clock as clock 1.
    $display("[TB] frame 0xA5, P=8, even parity");
    Prescale = PW'(8); PAR_EN = 1'b1; PAR_TYP = PAR_EVEN;
    push_expect(1'b1, 1'b0, 1'b0, 8'hA5, cyc + 1 + 88);
    apply_stimulus(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    check_output("p_data_held_a5", 32'(P_DATA), 32'hA5);

    // P=16 odd parity, 0x3C with wrong parity bit 0.
    $display("[TB] frame 0x3C, P=16, odd parity, bad parity bit");
    Prescale = PW'(16); PAR_EN = 1'b1; PAR_TYP = PAR_ODD;
    push_expect(1'b0, 1'b1, 1'b0, 8'hA5, cyc + 1 + 176);
    apply_stimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);

    // P=8 no parity, 0x55 with stop bit 0.
    $display("[TB] frame 0x55, P=8, bad stop bit");
    Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
    push_expect(1'b0, 1'b0, 1'b1, 8'hA5, cyc + 1 + 80);
    apply_stimulus(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check_output("p_data_after_errors", 32'(P_DATA), 32'hA5);

    // P=16 three-clock low glitch is rejected, then 0x81 is received.
    $display("[TB] start glitch then frame 0x81, P=16");
    Prescale = PW'(16); PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    push_expect(1'b1, 1'b0, 1'b0, 8'h81, cyc + 1 + 160);
    apply_stimulus(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);

    // P=32 back-to-back 0x00 then 0xFF; the second start is seen one edge
    // late, so only the first pulse time is pinned.
    $display("[TB] back-to-back 0x00, 0xFF, P=32");
    Prescale = PW'(32); PAR_EN = 1'b0;
    push_expect(1'b1, 1'b0, 1'b0, 8'h00, cyc + 1 + 320);
    push_expect(1'b1, 1'b0, 1'b0, 8'hFF, -1);
    apply_stimulus(8'h00, 32, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'hFF, 32, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge CLK);
    check_output("p_data_held_ff", 32'(P_DATA), 32'hFF);

    // P=16 even parity, 0x3A with a one-clock glitch at every bit centre.
    $display("[TB] frame 0x3A with centre glitches, P=16");
    Prescale = PW'(16); PAR_EN = 1'b1; PAR_TYP = PAR_EVEN;
    push_expect(1'b1, 1'b0, 1'b0, 8'h3A, cyc + 1 + 176);
    apply_stimulus(8'h3A, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);

    // P=8 no parity, 0xC3; Prescale/PAR_EN/PAR_TYP change mid-frame.
    $display("[TB] frame 0xC3, P=8, configuration changed mid-frame");
    Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
    push_expect(1'b1, 1'b0, 1'b0, 8'hC3, cyc + 1 + 80);
    fork
      apply_stimulus(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (20) @(negedge CLK);
        Prescale = PW'(32); PAR_EN = 1'b1; PAR_TYP = PAR_ODD;
      end
    join
    repeat (4) @(negedge CLK);

    // Reset during data bit 4, then a clean 0x7E frame.
    $display("[TB] reset mid-frame, then frame 0x7E, P=8");
    Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
    drive_bit(1'b0, 8, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, 1'b0);
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_output("midframe_reset_p_data", 32'(P_DATA), 32'h0);
    check_output("midframe_reset_pulses", {29'd0, data_valid, par_err, stp_err}, 32'h0);
    RX_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    push_expect(1'b1, 1'b0, 1'b0, 8'h7E, cyc + 1 + 80);
    apply_stimulus(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge CLK);

    check_output("pending_expectations", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
